// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte handshake and serial-line signals of the UART transmitter
interface uart_tx_serializer_if #(
    parameter int DATA_W = 8
) ();
    logic              tx_start;
    logic [DATA_W-1:0] tx_din;
    logic              tx_ready;
    logic              tx_busy;
    logic              tx_data;
    logic              shift;
    logic              tx_done;
    modport master (output tx_start, tx_din, input tx_ready, tx_busy, tx_data, shift, tx_done);
    modport slave  (input tx_start, tx_din, output tx_ready, tx_busy, tx_data, shift, tx_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames a byte as start, LSB-first data, optional even parity and stop bit
module uart_tx_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input logic                clk,
    input logic                clr,
    uart_tx_serializer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_MID  = BW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);
    state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [CW-1:0] bit_cnt, bit_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic par, par_n, last;
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        sreg_n  = sreg;
        par_n   = par;
        last    = baud == BAUD_LAST;
        baud_n  = (state == IDLE || last) ? '0 : baud + 1'b1;
        case (state)
            IDLE: if (bus.tx_start) begin
                state_n = START;
                sreg_n  = bus.tx_din;
                par_n   = ^bus.tx_din;
            end
            START:  state_n = last ? DATA : START;
            DATA: if (last) begin
                sreg_n  = sreg >> 1;
                bit_n   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                state_n = (bit_cnt != BIT_LAST) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: state_n = last ? STOP : PARITY;
            STOP:   state_n = last ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are decoded from the next-state values so they line up with the state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            baud         <= '0;
            bit_cnt      <= '0;
            sreg         <= '0;
            par          <= 1'b0;
            bus.tx_data  <= 1'b1;
            bus.tx_ready <= 1'b1;
            bus.tx_busy  <= 1'b0;
            bus.shift    <= 1'b0;
            bus.tx_done  <= 1'b0;
        end else begin
            state        <= state_n;
            baud         <= baud_n;
            bit_cnt      <= bit_n;
            sreg         <= sreg_n;
            par          <= par_n;
            bus.tx_data  <= (state_n == START) ? 1'b0 : (state_n == DATA) ? sreg_n[0] :
                            (state_n == PARITY) ? par_n : 1'b1;
            bus.tx_ready <= state_n == IDLE;
            bus.tx_busy  <= state_n != IDLE;
            bus.shift    <= state_n == DATA && baud_n == BAUD_MID;
            bus.tx_done  <= state == STOP && last;
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: checks framing, strobes, loopback, parity, back-to-back and reset abort
module tb_uart_tx_serializer;
    localparam int CPB = 4;
    localparam int DW  = 8;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;
    uart_tx_serializer_if #(.DATA_W(DW)) i0 ();
    uart_tx_serializer_if #(.DATA_W(DW)) i1 ();
    uart_tx_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u0 (.clk(clk), .clr(clr), .bus(i0.slave));
    uart_tx_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u1 (.clk(clk), .clr(clr), .bus(i1.slave));
    logic          st [2];
    logic [DW-1:0] din[2];
    logic [DW-1:0] rx [2];
    int vectors = 0;
    int miscompares = 0;
    assign i0.tx_start = st[0];
    assign i0.tx_din   = din[0];
    assign i1.tx_start = st[1];
    assign i1.tx_din   = din[1];
    // Receive-side loopback registers: insert at MSB, shift right on each strobe.
    always @(posedge clk) begin
        if (i0.shift) rx[0] <= {i0.tx_data, rx[0][DW-1:1]};
        if (i1.shift) rx[1] <= {i1.tx_data, rx[1][DW-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {tx_data, shift, tx_ready, tx_busy, tx_done}.
    task automatic check_cycle(input int sel, input string tag, input logic e_data, input logic e_shift,
                               input logic e_ready, input logic e_done);
        logic [4:0] o;
        o = sel == 1 ? {i1.tx_data, i1.shift, i1.tx_ready, i1.tx_busy, i1.tx_done}
                     : {i0.tx_data, i0.shift, i0.tx_ready, i0.tx_busy, i0.tx_done};
        chk(tag, 32'(o), 32'({e_data, e_shift, e_ready, ~e_ready, e_done}));
    endtask

    // Expected {line, strobe} at cycle c of a frame, counted from the first start-bit cycle.
    function automatic logic [1:0] model(input logic [DW-1:0] d, input bit pe, input int c);
        int idx;
        logic b;
        idx = c / CPB;
        if (idx == 0) b = 1'b0;
        else if (idx <= DW) b = d[idx-1];
        else if (pe && idx == DW + 1) b = ($countones(d) % 2) == 1;
        else b = 1'b1;
        return {b, idx >= 1 && idx <= DW && (c % CPB) == CPB / 2};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle(0, "idle0", 1'b1, 1'b0, 1'b1, 1'b0);
            check_cycle(1, "idle1", 1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic kick(input int sel, input logic [DW-1:0] d);
        chk($sformatf("ready%0d", sel), 32'(sel == 1 ? i1.tx_ready : i0.tx_ready), 32'd1);
        st[sel]  = 1'b1;
        din[sel] = d;
    endtask

    // Checks one frame cycle by cycle; non-chained frames also get a mid-frame start pulse.
    task automatic frame(input int sel, input logic [DW-1:0] d, input bit chain, input logic [DW-1:0] nd);
        int len;
        logic [1:0] m;
        len = (DW + 2 + sel) * CPB;
        @(negedge clk);
        for (int c = 0; c < len; c++) begin
            m = model(d, sel == 1, c);
            if (!chain) st[sel] = (c == 13);
            din[sel] = DW'($urandom);
            check_cycle(sel, $sformatf("frm%0d_%0h_c%0d", sel, d, c), m[1], m[0], 1'b0, 1'b0);
            @(negedge clk);
        end
        check_cycle(sel, $sformatf("done%0d_%0h", sel, d), 1'b1, 1'b0, 1'b1, 1'b1);
        chk($sformatf("rx%0d_%0h", sel, d), 32'(rx[sel]), 32'(d));
        if (chain) din[sel] = nd;
        else st[sel] = 1'b0;
    endtask

    initial begin
        st[0] = 1'b0; st[1] = 1'b0;
        din[0] = '0;  din[1] = '0;
        repeat (3) @(negedge clk);
        check_cycle(0, "rst0", 1'b1, 1'b0, 1'b1, 1'b0);
        check_cycle(1, "rst1", 1'b1, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        idle(20);
        kick(0, 8'hA5); frame(0, 8'hA5, 0, 8'h00); idle(2);
        kick(0, 8'h3C); frame(0, 8'h3C, 0, 8'h00); idle(2);
        kick(0, 8'hFF); frame(0, 8'hFF, 0, 8'h00); idle(2);
        kick(1, 8'h07); frame(1, 8'h07, 0, 8'h00); idle(2);
        kick(1, 8'h03); frame(1, 8'h03, 0, 8'h00); idle(2);
        kick(0, 8'h55); frame(0, 8'h55, 1, 8'h81); frame(0, 8'h81, 0, 8'h00); idle(50);
        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            kick(i % 2, d); frame(i % 2, d, 0, 8'h00); idle(1);
        end
        kick(0, 8'hF0);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b0;
        #1;
        check_cycle(0, "rst_abort", 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        idle(2);
        kick(0, 8'h12); frame(0, 8'h12, 0, 8'h00); idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
